// File: rtl/gray_seq_ctrl.sv
// Command-driven sequencer for an N-bit Gray-code counter.
// Binary and Gray views are registered together from the same next binary value.
module gray_seq_ctrl #(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [N-1:0] cmd_data,
   input  logic [N-1:0] cfg_limit,
   input  logic         cfg_dir,
   input  logic         cfg_mode,
   input  logic         step,
   output logic [N-1:0] bin_out,
   output logic [N-1:0] gray_out,
   output logic         running,
   output logic         done,
   output logic         wrap
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_HOLD = 2'b10,
      S_DONE = 2'b11
   } state_t;

   localparam logic [1:0] OP_START = 2'b00;
   localparam logic [1:0] OP_STOP  = 2'b01;
   localparam logic [1:0] OP_LOAD  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   state_t       state;
   logic [N-1:0] limit_q;
   logic [N-1:0] base_q;
   logic         dir_q;
   logic         mode_q;

   logic         accept;
   logic         start_acc;
   logic         stop_acc;
   logic         load_acc;
   logic         clear_acc;
   logic         at_limit;
   logic         idle_or_hold;
   logic [N-1:0] bin_nxt;

   assign accept       = cmd_valid && cmd_ready;
   assign start_acc    = accept && (cmd_op == OP_START);
   assign stop_acc     = accept && (cmd_op == OP_STOP);
   assign load_acc     = accept && (cmd_op == OP_LOAD);
   assign clear_acc    = accept && (cmd_op == OP_CLEAR);
   assign at_limit     = (bin_out == limit_q);
   assign idle_or_hold = (state == S_IDLE) || (state == S_HOLD);

   // Next binary count; CLEAR beats STOP beats step, START/LOAD in RUN are ignored
   always_comb begin
      bin_nxt = bin_out;
      if (clear_acc) begin
         bin_nxt = '0;
      end else if (state == S_RUN) begin
         if (!stop_acc && step) begin
            if (!at_limit) begin
               bin_nxt = dir_q ? (bin_out - N'(1)) : (bin_out + N'(1));
            end else if (!mode_q) begin
               bin_nxt = base_q;
            end
         end
      end else if (idle_or_hold && load_acc) begin
         bin_nxt = cmd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= S_IDLE;
         bin_out   <= '0;
         gray_out  <= '0;
         limit_q   <= '0;
         base_q    <= '0;
         dir_q     <= 1'b0;
         mode_q    <= 1'b0;
         running   <= 1'b0;
         done      <= 1'b0;
         wrap      <= 1'b0;
         cmd_ready <= 1'b0;
      end else begin
         bin_out   <= bin_nxt;
         gray_out  <= bin_nxt ^ (bin_nxt >> 1);
         running   <= 1'b0;
         done      <= 1'b0;
         wrap      <= 1'b0;
         cmd_ready <= 1'b1;
         case (state)
            S_IDLE, S_HOLD: begin
               if (clear_acc) begin
                  state <= S_IDLE;
               end else if (start_acc) begin
                  state   <= S_RUN;
                  running <= 1'b1;
                  limit_q <= cfg_limit;
                  dir_q   <= cfg_dir;
                  mode_q  <= cfg_mode;
                  base_q  <= bin_out;
               end
            end
            S_RUN: begin
               if (clear_acc) begin
                  state <= S_IDLE;
               end else if (stop_acc) begin
                  state <= S_HOLD;
               end else if (step && at_limit && mode_q) begin
                  state     <= S_DONE;
                  done      <= 1'b1;
                  cmd_ready <= 1'b0;
               end else begin
                  running <= 1'b1;
                  wrap    <= step && at_limit;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
